// File: rtl/noc_flit_injector.sv
// Credit-based flit injector: buffers core requests in a small FIFO and launches
// them onto the network send port one flit per edge while VC 0 has credits.
module noc_flit_injector #(
  parameter int FLIT_DATA_WIDTH = 64,
  parameter int DEST_BITS       = 1,
  parameter int VC_BITS         = 1,
  parameter int NUM_CREDITS     = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                        CLK,
  input  logic                                        RST,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic [DEST_BITS-1:0]                        req_dest,
  input  logic                                        req_tail,
  input  logic [FLIT_DATA_WIDTH-1:0]                  req_data,
  output logic [FLIT_DATA_WIDTH+DEST_BITS+VC_BITS+1:0] flit_out,
  output logic                                        put_flit_en,
  input  logic [VC_BITS:0]                            credit_in,
  output logic                                        get_credits_en,
  output logic [$clog2(NUM_CREDITS+1)-1:0]            credits_avail,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]             fifo_count,
  output logic                                        credit_err
);

  localparam int FLIT_W = FLIT_DATA_WIDTH + DEST_BITS + VC_BITS + 2;
  localparam int CRED_W = $clog2(NUM_CREDITS + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(NUM_CREDITS);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [DEST_BITS-1:0]       dest;
    logic                       tail;
    logic [FLIT_DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t              mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CRED_W-1:0]   credits_q, credits_d;
  logic                err_q, err_d;
  logic [FLIT_W-1:0]   flit_q, flit_d;
  logic                put_q, put_d;

  logic                push;
  logic                launch;
  logic                cred_ret;
  entry_t              head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign head = mem_q[rd_ptr_q];

  // Ready is driven only by the pre-edge occupancy, so a full FIFO refuses a
  // push even on an edge where it also pops.
  assign req_ready      = !RST && (count_q < CNT_MAX);
  assign get_credits_en = !RST;

  assign flit_out      = flit_q;
  assign put_flit_en   = put_q;
  assign credits_avail = credits_q;
  assign fifo_count    = count_q;
  assign credit_err    = err_q;

  // NOTE: every variable gets a default at the top of always_comb; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    push      = req_valid && req_ready;
    launch    = (count_q != '0) && (credits_q != '0);
    cred_ret  = credit_in[VC_BITS] && (credit_in[VC_BITS-1:0] == '0);

    wr_ptr_d  = push   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = launch ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d   = count_q;
    if (push && !launch) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && launch) begin
      count_d = count_q - CNT_W'(1);
    end

    credits_d = credits_q;
    err_d     = err_q;
    if (launch && !cred_ret) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (cred_ret && !launch) begin
      // A return with nothing outstanding is a network protocol error.
      if (credits_q == CRED_MAX) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CRED_W'(1);
      end
    end

    put_d  = launch;
    flit_d = launch ? {1'b1, head.tail, head.dest, {VC_BITS{1'b0}}, head.data} : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      credits_q <= CRED_MAX;
      err_q     <= 1'b0;
      flit_q    <= '0;
      put_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      flit_q    <= flit_d;
      put_q     <= put_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers and count alone decide
  // which entries are meaningful, and the array stays plain RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{dest: req_dest, tail: req_tail, data: req_data};
    end
  end

endmodule

// File: tb/tb_noc_flit_injector.sv
// Randomised and directed bench for noc_flit_injector: a queue-based reference
// model predicts launches into a scoreboard that a negedge monitor drains.
module tb_noc_flit_injector;

  localparam int DW = 64;
  localparam int DB = 1;
  localparam int VB = 1;
  localparam int NC = 8;
  localparam int FD = 4;
  localparam int FW = DW + DB + VB + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [DB-1:0]     req_dest;
  logic              req_tail;
  logic [DW-1:0]     req_data;
  logic [FW-1:0]     flit_out;
  logic              put_flit_en;
  logic [VB:0]       credit_in;
  logic              get_credits_en;
  logic [3:0]        credits_avail;
  logic [2:0]        fifo_count;
  logic              credit_err;

  noc_flit_injector #(
    .FLIT_DATA_WIDTH(DW), .DEST_BITS(DB), .VC_BITS(VB),
    .NUM_CREDITS(NC), .FIFO_DEPTH(FD)
  ) dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_tail(req_tail), .req_data(req_data),
    .flit_out(flit_out), .put_flit_en(put_flit_en),
    .credit_in(credit_in), .get_credits_en(get_credits_en),
    .credits_avail(credits_avail), .fifo_count(fifo_count),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: requests waiting for the network, free credits, sticky error.
  typedef struct {
    logic [DB-1:0] dest;
    logic          tail;
    logic [DW-1:0] data;
  } req_t;

  req_t          m_q[$];
  logic [FW-1:0] m_sb[$];
  int            m_credits = NC;
  bit            m_err = 1'b0;
  bit            m_acc = 1'b0;
  bit            m_live = 1'b0;

  always @(posedge clk) begin : model
    bit   acc, lau, ret;
    req_t e;
    if (rst) begin
      m_q.delete();
      m_sb.delete();
      m_credits = NC;
      m_err     = 1'b0;
      m_acc     = 1'b0;
      m_live    = 1'b1;
    end else if (m_live) begin
      acc = req_valid && (m_q.size() < FD);
      lau = (m_q.size() > 0) && (m_credits > 0);
      ret = credit_in[VB] && (credit_in[VB-1:0] == '0);
      if (lau) begin
        e = m_q.pop_front();
        m_sb.push_back({1'b1, e.tail, e.dest, {VB{1'b0}}, e.data});
      end
      if (acc) m_q.push_back('{req_dest, req_tail, req_data});
      if (lau && !ret) m_credits--;
      else if (ret && !lau) begin
        if (m_credits == NC) m_err = 1'b1;
        else m_credits++;
      end
      m_acc = acc;
    end
  end

  always @(negedge clk) begin : monitor
    logic [FW-1:0] exp_flit;
    if (m_live) begin
      check("req_ready", req_ready, !rst && (m_q.size() < FD));
      check("get_credits_en", get_credits_en, !rst);
      check("credits_avail", credits_avail, m_credits);
      check("fifo_count", fifo_count, m_q.size());
      check("credit_err", credit_err, m_err);
      if (m_sb.size() > 0) begin
        exp_flit = m_sb.pop_front();
        check("put_flit_en", put_flit_en, 1'b1);
        check("flit_out", flit_out, exp_flit);
      end else begin
        check("put_flit_en", put_flit_en, 1'b0);
        check("flit_out_idle", flit_out, '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  task automatic credit(input logic [VB-1:0] vc, input int n);
    credit_in = {1'b1, vc};
    idle(n);
    credit_in = '0;
  endtask

  task automatic send(input logic [DB-1:0] d, input logic t, input logic [DW-1:0] data);
    req_valid = 1'b1;
    req_dest  = d;
    req_tail  = t;
    req_data  = data;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (m_acc) begin
        req_valid = 1'b0;
        return;
      end
    end
    req_valid = 1'b0;
    check("send_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_dest = '0; req_tail = 1'b0;
    req_data = '0; credit_in = '0;
    do_reset(2);

    // Single flit, 8 -> 7 credits.
    send(1'b0, 1'b0, 64'h8);
    idle(3);

    // Credit exhaustion: 10 requests, 8 launch, 8 and 9 wait; one credit frees 8.
    do_reset(1);
    for (int i = 0; i < 10; i++) send(1'(i), 1'(i % 3 == 2), 64'(i));
    idle(4);
    credit(1'b0, 1);
    idle(4);

    // Full FIFO at zero credits, then trickle credits across the pointer wrap.
    do_reset(1);
    for (int i = 0; i < 8; i++) send(1'b0, 1'b0, 64'h100 + 64'(i));
    idle(3);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b1, 64'h200 + 64'(i));
    idle(2);
    req_valid = 1'b1; req_data = 64'h250; req_dest = 1'b0; req_tail = 1'b0;
    credit(1'b0, 1);
    send(1'b0, 1'b0, 64'h250);
    for (int i = 0; i < 6; i++) begin
      credit(1'b0, 1);
      idle(1);
    end
    idle(2);

    // Launch with simultaneous credit return at 5 credits, then a wrong-VC return.
    do_reset(1);
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 64'h300 + 64'(i));
    idle(3);
    send(1'b1, 1'b1, 64'h3aa);
    credit(1'b0, 1);
    idle(1);
    credit(1'b1, 1);
    idle(2);

    // Overflow: credit returned with a full credit count and an idle FIFO.
    do_reset(1);
    idle(1);
    credit(1'b0, 1);
    idle(3);
    send(1'b0, 1'b1, 64'h400);
    idle(3);

    // Mid-operation reset with three flits buffered.
    do_reset(1);
    for (int i = 0; i < 8; i++) send(1'b0, 1'b0, 64'h500 + 64'(i));
    idle(3);
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 64'h600 + 64'(i));
    credit(1'b0, 1);
    do_reset(1);
    idle(5);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_dest  = 1'($urandom_range(0, 1));
      req_tail  = 1'($urandom_range(0, 1));
      req_data  = {$urandom, $urandom};
      credit_in = {1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 3) == 0)};
      rst       = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; req_valid = 1'b0; credit_in = '0;
    for (int i = 0; i < 12; i++) credit(1'b0, 1);
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
